inv_arbiter: RTL and testbench

//  Shares one GF(2^255-19) modular-inverter core between NREQ requesters. Round-robin grant, drives the

---
 rtl/inv_arb_pkg.sv | 18 +
 rtl/inv_arbiter_rr_arbiter.sv | 51 +++++
 rtl/inv_arbiter.sv | 165 ++++++++++++++++
 tb/tb_inv_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_arb_pkg.sv
// rtl/inv_arb_pkg.sv - shared types and constants for the modular-inverter arbiter
package inv_arb_pkg;

    localparam int FE_W = 255;

    typedef logic [FE_W-1:0] fe_t;

    // Field prime 2^255 - 19
    localparam fe_t P = ~fe_t'(0) - fe_t'(18);

    typedef enum logic [1:0] {
        IDLE,
        DROP,
        RISE,
        RESP
    } state_t;

endpackage

// File: rtl/inv_arbiter_rr_arbiter.sv
// rtl/inv_arbiter_rr_arbiter.sv - round-robin grant with pointer advance on accept
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            accept,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] cand;

    // Scan from the farthest offset down so the nearest requester at/after ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && gnt_any) begin
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/inv_arbiter.sv
// rtl/inv_arbiter.sv - shares one GF(2^255-19) inverter core among NREQ requesters
// Optional watchdog enabled by defining INV_ARB_WDOG_EN.
module inv_arbiter
    import inv_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int FE_W        = 255,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*FE_W-1:0]     req_a,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [FE_W-1:0]          rsp_inv,
    output logic                     rsp_err,
    output logic [FE_W-1:0]          inv_a,
    input  logic [FE_W-1:0]          inv_result,
    input  logic                     inv_valid,
    output logic                     inv_kick,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || WDOG_CYCLES < 2) begin : g_bad_param
        $error("inv_arbiter: NREQ must be 2..8 and WDOG_CYCLES at least 2");
    end

    state_t           state_q, state_d;
    logic [FE_W-1:0]  inv_a_q, inv_a_d;
    logic [FE_W-1:0]  cache_q, cache_d;
    logic             cache_vld_q, cache_vld_d;
    logic             rsp_err_q, rsp_err_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic             accept;
    logic [FE_W-1:0]  gnt_a;
    logic             wdog_fire;

    assign accept = (state_q == IDLE) && !rst && gnt_any;
    assign gnt_a  = req_a[int'(gnt_idx) * FE_W +: FE_W];

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

`ifdef INV_ARB_WDOG_EN
    localparam int WDW = $clog2(WDOG_CYCLES + 1);

    logic [WDW-1:0] wdog_q, wdog_d;
    logic           inv_kick_q;

    // Counts every cycle spent waiting on the core; idle time keeps it at zero.
    always_comb begin
        wdog_d    = '0;
        wdog_fire = 1'b0;
        if (state_q == DROP || state_q == RISE) begin
            wdog_d    = wdog_q + 1'b1;
            wdog_fire = (wdog_q == WDW'(WDOG_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q     <= '0;
            inv_kick_q <= 1'b0;
        end else begin
            wdog_q     <= wdog_d;
            inv_kick_q <= wdog_fire;
        end
    end

    assign inv_kick = inv_kick_q;
`else
    assign wdog_fire = 1'b0;
    assign inv_kick  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        inv_a_d     = inv_a_q;
        cache_d     = cache_q;
        cache_vld_d = cache_vld_q;
        rsp_err_d   = rsp_err_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rsp_id_d  = gnt_idx;
                    rsp_err_d = 1'b0;
                    if (gnt_a == '0) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else if (cache_vld_q && gnt_a == inv_a_q) begin
                        state_d = RESP;
                    end else begin
                        inv_a_d     = gnt_a;
                        cache_vld_d = 1'b0;
                        state_d     = DROP;
                    end
                end
            end
            DROP, RISE: begin
                if (wdog_fire) begin
                    inv_a_d     = '0;
                    cache_vld_d = 1'b0;
                    rsp_err_d   = 1'b1;
                    state_d     = RESP;
                end else if (state_q == DROP && !inv_valid) begin
                    state_d = RISE;
                end else if (state_q == RISE && inv_valid) begin
                    cache_d     = inv_result;
                    cache_vld_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            inv_a_q     <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            inv_a_q     <= inv_a_d;
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
            rsp_err_q   <= rsp_err_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign req_ready = accept ? gnt : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_valid && rsp_err_q;
    assign rsp_inv   = (rsp_valid && !rsp_err_q) ? cache_q : '0;
    assign inv_a     = inv_a_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inv_arbiter.sv
// tb/tb_inv_arbiter.sv - directed bench for inv_arbiter with a behavioural inverter stub
module tb_inv_arbiter;
    import inv_arb_pkg::*;

    localparam int NREQ     = 4;
    localparam int CORE_LAT = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ*FE_W-1:0]    req_a;
    logic [NREQ-1:0]         req_ready;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [1:0]              rsp_id;
    logic [FE_W-1:0]         rsp_inv;
    logic                    rsp_err;
    logic [FE_W-1:0]         inv_a;
    logic [FE_W-1:0]         inv_result;
    logic                    inv_valid;
    logic                    inv_kick;
    logic                    busy;

    int vectors = 0;
    int fails   = 0;

    fe_t inv2, inv3, inv4;
    logic [511:0] wide;

    fe_t  core_a;
    logic core_valid;
    int   core_cnt;
    logic core_hang;

    inv_arbiter #(.NREQ(NREQ), .FE_W(FE_W), .WDOG_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_inv    (rsp_inv),
        .rsp_err    (rsp_err),
        .inv_a      (inv_a),
        .inv_result (inv_result),
        .inv_valid  (inv_valid),
        .inv_kick   (inv_kick),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic fe_t stub_inv(input fe_t a);
        if (a == fe_t'(1))      return fe_t'(1);
        if (a == fe_t'(2))      return inv2;
        if (a == fe_t'(3))      return inv3;
        if (a == fe_t'(4))      return inv4;
        if (a == P - fe_t'(1))  return P - fe_t'(1);
        return '0;
    endfunction

    // Level-valid core: drops valid when its operand changes, raises it CORE_LAT cycles later.
    always @(posedge clk) begin
        if (rst || inv_kick) begin
            core_a     <= '0;
            core_valid <= 1'b0;
            core_cnt   <= 0;
        end else if (inv_a != core_a) begin
            core_a     <= inv_a;
            core_valid <= 1'b0;
            core_cnt   <= CORE_LAT;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1 && !core_hang && core_a != '0) core_valid <= 1'b1;
        end
    end

    assign inv_valid  = core_valid;
    assign inv_result = stub_inv(core_a);

    function automatic logic is_inverse(input fe_t x, input fe_t a);
        logic [511:0] prod;
        prod = {257'b0, x} * {257'b0, a};
        prod = prod % {257'b0, P};
        return prod == 512'd1;
    endfunction

    task automatic issue(input int idx, input fe_t a, output int gcyc);
        req_valid[idx] = 1'b1;
        req_a[idx*FE_W +: FE_W] = a;
        gcyc = -1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (req_ready[idx]) begin
                gcyc = i;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 200; i++) begin
            if (rsp_valid) begin
                cyc = i;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({req_ready, rsp_valid, rsp_err, busy, inv_kick} !== 9'b0 || rsp_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_ctrl: ready=%b rv=%b err=%b busy=%b kick=%b id=%0d, want all 0",
                     req_ready, rsp_valid, rsp_err, busy, inv_kick, rsp_id);
        end
        vectors++;
        if (inv_a !== '0 || rsp_inv !== '0) begin
            fails++;
            $display("FAIL reset_data: inv_a=%h rsp_inv=%h, want 0", inv_a, rsp_inv);
        end
    endtask

    task automatic test_core_path();
        int g, c;
        issue(0, fe_t'(2), g);
        wait_rsp(c);
        vectors++;
        if (g < 0 || c < 0) begin
            fails++;
            $display("FAIL core_timeout: grant=%0d rsp=%0d, want both >=0", g, c);
        end
        vectors++;
        if (rsp_id !== 2'd0 || rsp_err !== 1'b0 || rsp_inv !== inv2) begin
            fails++;
            $display("FAIL core_rsp: id=%0d err=%b inv=%h, want 0 0 %h", rsp_id, rsp_err, rsp_inv, inv2);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            vectors++;
            if (inv_a !== fe_t'(2) || rsp_valid !== 1'b1) begin
                fails++;
                $display("FAIL core_hold: inv_a=%h rv=%b, want 2 1", inv_a, rsp_valid);
            end
        end
        ack();
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL core_release: rv=%b busy=%b, want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_cache_hit();
        int g, c;
        issue(1, fe_t'(2), g);
        wait_rsp(c);
        vectors++;
        if (c !== 1) begin
            fails++;
            $display("FAIL hit_latency: cycles=%0d, want 1", c);
        end
        vectors++;
        if (rsp_id !== 2'd1 || rsp_err !== 1'b0 || rsp_inv !== inv2 || inv_valid !== 1'b1) begin
            fails++;
            $display("FAIL hit_rsp: id=%0d err=%b inv=%h inv_valid=%b, want 1 0 %h 1",
                     rsp_id, rsp_err, rsp_inv, inv_valid, inv2);
        end
        ack();
    endtask

    task automatic test_zero();
        int g, c;
        issue(2, fe_t'(0), g);
        wait_rsp(c);
        vectors++;
        if (c !== 1) begin
            fails++;
            $display("FAIL zero_latency: cycles=%0d, want 1", c);
        end
        vectors++;
        if (rsp_id !== 2'd2 || rsp_err !== 1'b1 || rsp_inv !== '0 || inv_a !== fe_t'(2)) begin
            fails++;
            $display("FAIL zero_rsp: id=%0d err=%b inv=%h inv_a=%h, want 2 1 0 2",
                     rsp_id, rsp_err, rsp_inv, inv_a);
        end
        ack();
    endtask

    task automatic test_round_robin();
        fe_t ops [4];
        fe_t held;
        int c, w;
        ops[0] = fe_t'(1);
        ops[1] = fe_t'(3);
        ops[2] = fe_t'(4);
        ops[3] = P - fe_t'(1);
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = 1'b1;
            req_a[i*FE_W +: FE_W] = ops[i];
        end
        for (int k = 0; k < NREQ; k++) begin
            w = -1;
            for (int i = 0; i < 100; i++) begin
                #1;
                if (req_ready != '0) begin
                    w = i;
                    break;
                end
                @(negedge clk);
            end
            vectors++;
            if (w < 0 || req_ready !== (4'b0001 << k)) begin
                fails++;
                $display("FAIL rr_grant%0d: ready=%b wait=%0d, want %b", k, req_ready, w, 4'b0001 << k);
            end
            @(negedge clk);
            req_valid[k] = 1'b0;
            #1;
            wait_rsp(c);
            vectors++;
            if (c < 0 || rsp_id !== 2'(k) || rsp_err !== 1'b0 || !is_inverse(rsp_inv, ops[k])) begin
                fails++;
                $display("FAIL rr_rsp%0d: cycles=%0d id=%0d err=%b inv=%h", k, c, rsp_id, rsp_err, rsp_inv);
            end
            if (k == 0) begin
                held = rsp_inv;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    #1;
                    vectors++;
                    if (rsp_valid !== 1'b1 || rsp_inv !== held || req_ready !== 4'b0) begin
                        fails++;
                        $display("FAIL rr_stall%0d: rv=%b inv=%h ready=%b, want 1 %h 0000",
                                 s, rsp_valid, rsp_inv, req_ready, held);
                    end
                end
            end
            ack();
        end
    endtask

    task automatic test_reset_mid_op();
        int g, c;
        issue(0, fe_t'(3), g);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        req_valid[1] = 1'b1;
        req_a[1*FE_W +: FE_W] = fe_t'(5);
        #1;
        vectors++;
        if (req_ready !== 4'b0) begin
            fails++;
            $display("FAIL rst_no_grant: ready=%b, want 0000", req_ready);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || inv_a !== '0 || rsp_inv !== '0 ||
            rsp_err !== 1'b0 || rsp_id !== 2'd0 || inv_kick !== 1'b0 || req_ready !== 4'b0) begin
            fails++;
            $display("FAIL rst_mid: busy=%b rv=%b inv_a=%h err=%b id=%0d ready=%b, want all 0",
                     busy, rsp_valid, inv_a, rsp_err, rsp_id, req_ready);
        end
        rst = 1'b0;
        req_valid[1] = 1'b0;
        issue(2, fe_t'(3), g);
        wait_rsp(c);
        vectors++;
        if (c < 2 || rsp_id !== 2'd2 || rsp_err !== 1'b0 || rsp_inv !== inv3) begin
            fails++;
            $display("FAIL rst_recover: cycles=%0d id=%0d err=%b inv=%h, want >=2 2 0 %h",
                     c, rsp_id, rsp_err, rsp_inv, inv3);
        end
        ack();
    endtask

`ifdef INV_ARB_WDOG_EN
    task automatic test_watchdog();
        int g, w;
        core_hang = 1'b1;
        issue(3, fe_t'(4), g);
        w = -1;
        for (int i = 0; i < 100; i++) begin
            if (inv_kick) begin
                w = i;
                break;
            end
            @(negedge clk);
            #1;
        end
        vectors++;
        if (w < 0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_inv !== '0 || inv_a !== '0) begin
            fails++;
            $display("FAIL wdog_fire: wait=%0d rv=%b err=%b inv=%h inv_a=%h, want >=0 1 1 0 0",
                     w, rsp_valid, rsp_err, rsp_inv, inv_a);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (inv_kick !== 1'b0) begin
            fails++;
            $display("FAIL wdog_pulse: kick=%b, want 0", inv_kick);
        end
        ack();
        core_hang = 1'b0;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        rsp_ready = 1'b0;
        core_hang = 1'b0;
        wide = ({257'b0, P} + 512'd1) / 512'd2;
        inv2 = wide[FE_W-1:0];
        wide = ({257'b0, P} * 512'd2 + 512'd1) / 512'd3;
        inv3 = wide[FE_W-1:0];
        wide = ({257'b0, P} * 512'd3 + 512'd1) / 512'd4;
        inv4 = wide[FE_W-1:0];
        @(negedge clk);
        test_reset();
        test_core_path();
        test_cache_hit();
        test_zero();
        test_round_robin();
        test_reset_mid_op();
`ifdef INV_ARB_WDOG_EN
        test_watchdog();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
